// File: rtl/booth_mult_seq_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
// Define BOOTH_RADIX4_EN to build the radix-4 datapath. Leave it undefined for radix-2.
package booth_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} booth_state_t;

  // Recoded digit: bit 2 selects subtract, bits 1:0 give the magnitude (0, M or 2M).
  localparam logic [2:0] BOOTH_DIG_ZERO = 3'b000;
  localparam logic [2:0] BOOTH_DIG_POS1 = 3'b001;
  localparam logic [2:0] BOOTH_DIG_POS2 = 3'b010;
  localparam logic [2:0] BOOTH_DIG_NEG1 = 3'b101;
  localparam logic [2:0] BOOTH_DIG_NEG2 = 3'b110;

`ifdef BOOTH_RADIX4_EN
  localparam int BOOTH_STEP = 2;
`else
  localparam int BOOTH_STEP = 1;
`endif

  function automatic int booth_iters(input int width);
`ifdef BOOTH_RADIX4_EN
    return width / 2 + 1;
`else
    return width + 1;
`endif
  endfunction

  function automatic logic [2:0] booth_r4_digit(input logic [2:0] bits);
    logic [2:0] dig;
    dig = BOOTH_DIG_ZERO;
    case (bits)
      3'b001, 3'b010: dig = BOOTH_DIG_POS1;
      3'b011:         dig = BOOTH_DIG_POS2;
      3'b100:         dig = BOOTH_DIG_NEG2;
      3'b101, 3'b110: dig = BOOTH_DIG_NEG1;
      default:        dig = BOOTH_DIG_ZERO;
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Start/done handshake and operand/result bus of the Booth multiplier.
// The host drives it through the master modport, and the multiplier receives it through the slave modport.
interface booth_mult_seq_if #(parameter int WIDTH = 16) ();
  logic               start;
  logic               sgn;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (output start, sgn, mcand, mplier, input busy, done, product);
  modport slave  (input start, sgn, mcand, mplier, output busy, done, product);
endinterface

// File: rtl/booth_mult_seq_ctrl.sv
// Controller for the Booth multiplier: the IDLE/CALC/DONE FSM and the iteration down-counter.
// It emits load, iterate and finish strobes to the datapath.
import booth_pkg::*;

module booth_ctrl #(
  parameter int ITERS = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  output logic o_load,
  output logic o_iterate,
  output logic o_finish,
  output logic o_busy,
  output logic o_done
);
  localparam int CW = $clog2(ITERS + 1);

  booth_state_t r_state, w_stateNext;
  logic [CW-1:0] r_count, w_countNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_stateNext;
      r_count <= w_countNext;
    end
  end

  // DONE accepts start exactly like IDLE, so operations can run back-to-back.
  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    o_load      = 1'b0;
    o_iterate   = 1'b0;
    o_finish    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (i_start) begin
          o_load      = 1'b1;
          w_countNext = CW'(ITERS);
          w_stateNext = CALC;
        end else begin
          w_stateNext = IDLE;
        end
      end
      CALC: begin
        o_iterate   = 1'b1;
        w_countNext = r_count - CW'(1);
        if (r_count == CW'(1)) begin
          o_finish    = 1'b1;
          w_stateNext = DONE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign o_busy = (r_state == CALC);
  assign o_done = (r_state == DONE);
endmodule

// File: rtl/booth_mult_seq.sv
// Sequential Booth multiplier: the datapath (A, Q, Q-1, add/sub, shift) plus a booth_ctrl instance.
// Define BOOTH_RADIX4_EN to get radix-4 recoding with 2 bits per cycle. The default is radix-2.
import booth_pkg::*;

module booth_mult_seq #(
  parameter int WIDTH = 16
) (
  input logic           clk,
  input logic           rst,
  booth_mult_seq_if.slave bus
);
  localparam int EW    = WIDTH + 2;
  localparam int ITERS = booth_iters(WIDTH);
  localparam int STEP  = BOOTH_STEP;
  // Multiplier bits that are never shifted into the product sit below it in {A,Q}.
  localparam int DROP  = EW - ITERS * STEP;

  logic            w_load, w_iterate, w_finish;
  logic [EW-1:0]   r_accum, r_mq, r_mcand;
  logic            r_qm1;
  logic [2*WIDTH-1:0] r_product;
  logic [EW-1:0]   w_extMcand, w_extMplier, w_mag, w_sum;
  logic [2:0]      w_digit;
  logic [2*EW:0]   w_cat, w_shifted;

  booth_ctrl #(.ITERS(ITERS)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .i_start   (bus.start),
    .o_load    (w_load),
    .o_iterate (w_iterate),
    .o_finish  (w_finish),
    .o_busy    (bus.busy),
    .o_done    (bus.done)
  );

  assign w_extMcand  = bus.sgn ? {{2{bus.mcand[WIDTH-1]}}, bus.mcand}   : {2'b00, bus.mcand};
  assign w_extMplier = bus.sgn ? {{2{bus.mplier[WIDTH-1]}}, bus.mplier} : {2'b00, bus.mplier};

`ifdef BOOTH_RADIX4_EN
  assign w_digit = booth_r4_digit({r_mq[1], r_mq[0], r_qm1});
`else
  assign w_digit = ({r_mq[0], r_qm1} == 2'b01) ? BOOTH_DIG_POS1 :
                   ({r_mq[0], r_qm1} == 2'b10) ? BOOTH_DIG_NEG1 : BOOTH_DIG_ZERO;
`endif

  assign w_mag     = w_digit[1] ? {r_mcand[EW-2:0], 1'b0} : (w_digit[0] ? r_mcand : '0);
  assign w_sum     = w_digit[2] ? (r_accum - w_mag) : (r_accum + w_mag);
  assign w_cat     = {w_sum, r_mq, r_qm1};
  assign w_shifted = $signed(w_cat) >>> STEP;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_accum   <= '0;
      r_mq      <= '0;
      r_qm1     <= 1'b0;
      r_mcand   <= '0;
      r_product <= '0;
    end else begin
      if (w_load) begin
        r_accum <= '0;
        r_mq    <= w_extMplier;
        r_qm1   <= 1'b0;
        r_mcand <= w_extMcand;
      end else if (w_iterate) begin
        {r_accum, r_mq, r_qm1} <= w_shifted;
      end
      if (w_finish) begin
        r_product <= w_shifted[1+DROP +: 2*WIDTH];
      end
    end
  end

  assign bus.product = r_product;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq at WIDTH=16. Define BOOTH_RADIX4_EN to match a radix-4 build.
// The driver queues hand-computed products, and a monitor checks each done pulse for value and latency.
import booth_pkg::*;

module tb_booth_mult_seq;

`ifdef BOOTH_RADIX4_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 17;
`endif

  typedef struct {
    logic [31:0] prod;
    int          acceptCycle;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  exp_t monItem;

  booth_mult_seq_if #(.WIDTH(16)) bus ();

  booth_mult_seq #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL spurious done: got done=1 product=0x%0h required no done", bus.product);
      end else begin
        monItem = sb.pop_front();
        checkOutput({monItem.name, " product"}, 64'(bus.product), 64'(monItem.prod));
        checkOutput({monItem.name, " latency"}, 64'(cyc - monItem.acceptCycle), 64'(LAT));
      end
    end
  end

  task automatic applyStimulus(input string name, input logic s, input logic [15:0] a,
                               input logic [15:0] b, input logic [31:0] prod);
    exp_t e;
    bus.start  = 1'b1;
    bus.sgn    = s;
    bus.mcand  = a;
    bus.mplier = b;
    e.prod = prod;
    e.acceptCycle = cyc + 1;
    e.name = name;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput({name, " busy after start"}, 64'(bus.busy), 64'd1);
  endtask

  task automatic waitIdle(input string name);
    int n;
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.busy && !bus.done) break;
    end
    if (n >= 60) begin
      total++;
      bad++;
      $display("[TB] FAIL %s timeout: got %0d pending results required 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    bus.sgn = 1'b0;
    bus.mcand = '0;
    bus.mplier = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 64'(bus.busy), 64'd0);
    checkOutput("reset done", 64'(bus.done), 64'd0);
    checkOutput("reset product", 64'(bus.product), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus("3x7", 1'b1, 16'd3, 16'd7, 32'd21);                      waitIdle("3x7");
    applyStimulus("-5x7", 1'b1, 16'hFFFB, 16'd7, 32'hFFFF_FFDD);            waitIdle("-5x7");
    applyStimulus("min x min", 1'b1, 16'h8000, 16'h8000, 32'h4000_0000);    waitIdle("min x min");
    applyStimulus("u max x max", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);  waitIdle("u max x max");
    applyStimulus("-1x-1", 1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001);        waitIdle("-1x-1");
    applyStimulus("u 8000x3", 1'b0, 16'h8000, 16'd3, 32'h0001_8000);        waitIdle("u 8000x3");
    applyStimulus("s 8000x3", 1'b1, 16'h8000, 16'd3, 32'hFFFE_8000);        waitIdle("s 8000x3");
    applyStimulus("max x min", 1'b1, 16'h7FFF, 16'h8000, 32'hC000_8000);    waitIdle("max x min");
    applyStimulus("u 8000x8000", 1'b0, 16'h8000, 16'h8000, 32'h4000_0000);  waitIdle("u 8000x8000");
    applyStimulus("0x1234", 1'b1, 16'd0, 16'h1234, 32'd0);                  waitIdle("0x1234");

    // Second start while busy must be ignored
    applyStimulus("100x200", 1'b1, 16'd100, 16'd200, 32'h0000_4E20);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.sgn = 1'b0;
    bus.mcand = 16'd7;
    bus.mplier = 16'd7;
    @(negedge clk);
    bus.start = 1'b0;
    waitIdle("100x200");
    checkOutput("held product", 64'(bus.product), 64'h4E20);

    // Abort mid-operation with reset
    applyStimulus("abort", 1'b1, 16'd1234, 16'd5, 32'd6170);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    checkOutput("abort busy", 64'(bus.busy), 64'd0);
    checkOutput("abort done", 64'(bus.done), 64'd0);
    checkOutput("abort product", 64'(bus.product), 64'd0);
    rst = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    applyStimulus("6x6", 1'b1, 16'd6, 16'd6, 32'd36);                       waitIdle("6x6");

    // Start held during DONE is accepted back-to-back
    applyStimulus("9x9", 1'b1, 16'd9, 16'd9, 32'd81);
    for (n = 0; n < 40; n++) begin
      if (bus.done) break;
      @(negedge clk);
    end
    if (n >= 40) begin
      total++;
      bad++;
      $display("[TB] FAIL b2b wait: got done=0 required done=1");
    end
    applyStimulus("2x-3 b2b", 1'b1, 16'd2, 16'hFFFD, 32'hFFFF_FFFA);
    waitIdle("2x-3 b2b");

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL missing done: got %0d pending required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish required finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
